decode_ctrl_mac_seq: RTL and testbench

- Next-generation decode-stage controller for the pipelined RV32 core with the matrix-MAC extension.
- Decodes the base opcodes into control signals and registers them into the D/E pipeline register, with stall and flush support.
- Adds a parametrised matrix-MAC sequencer for the custom-0 opcode (7'b0001011). While the sequencer runs, it holds fetch and decode and issues element-indexed beats to the MAC array under a valid/ready handshake.

---
 rtl/decode_ctrl_mac_seq.sv | 254 +++++++++++++++++++++++++
 tb/tb_decode_ctrl_mac_seq.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_mac_seq.sv
// D-stage control decoder with D/E control register and matrix-MAC beat sequencer.
// The sequencer stalls fetch/decode while it walks element indices over the MAC array.
module decode_ctrl_mac_seq #(
   parameter int DIM   = 4,
   parameter int IDX_W = $clog2(DIM)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       op_d,
   input  logic [2:0]       funct3_d,
   input  logic [6:0]       funct7_d,
   input  logic             stall_d,
   input  logic             flush_d,
   input  logic             flush_e,
   input  logic             mac_ready,
   output logic [2:0]       imm_src_d,
   output logic             illegal_d,
   output logic             reg_write_e,
   output logic             mem_write_e,
   output logic             alu_src_e,
   output logic             jump_e,
   output logic             branch_e,
   output logic             wd3_src_e,
   output logic [1:0]       result_src_e,
   output logic [2:0]       alu_control_e,
   output logic             stall_fd,
   output logic             mac_valid,
   output logic [1:0]       mac_mode,
   output logic [IDX_W-1:0] mac_row,
   output logic [IDX_W-1:0] mac_col,
   output logic             mac_last,
   output logic             mac_busy
);

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JLR = 7'b1100111;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_C0  = 7'b0001011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;
   localparam logic [2:0] ALU_XOR = 3'b101;

   localparam logic [1:0] M_MATVEC = 2'd0;
   localparam logic [1:0] M_VEC    = 2'd1;
   localparam logic [1:0] M_CLR    = 2'd2;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DONE
   } state_e;

   logic       rw, mw, as, jp, br, wd;
   logic [1:0] rs;
   logic [2:0] alu;
   logic [2:0] imm;
   logic       ill;
   logic       mac_ok;

   logic [10:0] ctl_d, ctl_q;

   state_e           state_d, state_q;
   logic [IDX_W-1:0] row_d, row_q;
   logic [IDX_W-1:0] col_d, col_q;
   logic [1:0]       mode_d, mode_q;
   logic             valid_d, valid_q;
   logic             last_d, last_q;
   logic             busy_d, busy_q;
   logic             start;
   logic             accept;
   logic             bubble;

   assign mac_ok = (op_d == OP_C0) && !funct3_d[2] && (funct3_d[1:0] != 2'b11);

   always_comb begin
      rw  = 1'b0;
      mw  = 1'b0;
      as  = 1'b0;
      jp  = 1'b0;
      br  = 1'b0;
      wd  = 1'b0;
      rs  = 2'b00;
      alu = ALU_ADD;
      imm = 3'b000;
      ill = 1'b0;
      unique case (1'b1)
         (op_d == OP_R): begin
            rw = 1'b1;
            case ({funct7_d, funct3_d})
               10'd0:   alu = ALU_ADD;
               10'd256: alu = ALU_SUB;
               10'd7:   alu = ALU_AND;
               10'd6:   alu = ALU_OR;
               10'd2:   alu = ALU_SLT;
               default: ill = 1'b1;
            endcase
         end
         (op_d == OP_I): begin
            rw = 1'b1;
            as = 1'b1;
            case (funct3_d)
               3'b110:  alu = ALU_OR;
               3'b100:  alu = ALU_XOR;
               3'b010:  alu = ALU_SLT;
               default: alu = ALU_ADD;
            endcase
         end
         (op_d == OP_JLR): begin
            rw = 1'b1;
            jp = 1'b1;
            as = 1'b1;
            rs = 2'b10;
            wd = 1'b1;
         end
         (op_d == OP_LW): begin
            rw = 1'b1;
            as = 1'b1;
            rs = 2'b01;
         end
         (op_d == OP_SW): begin
            mw  = 1'b1;
            as  = 1'b1;
            imm = 3'b001;
         end
         (op_d == OP_BR): begin
            br  = 1'b1;
            imm = 3'b010;
            alu = funct3_d[2] ? ALU_SLT : ALU_SUB;
         end
         (op_d == OP_LUI): begin
            rw  = 1'b1;
            imm = 3'b011;
            rs  = 2'b11;
         end
         (op_d == OP_JAL): begin
            rw  = 1'b1;
            jp  = 1'b1;
            imm = 3'b100;
            rs  = 2'b10;
            wd  = 1'b1;
         end
         (op_d == OP_C0): ill = !mac_ok;
         default:         ill = 1'b1;
      endcase
   end

   assign imm_src_d = imm;
   assign illegal_d = ill;

   // Start is gated by rst so stall_fd stays low while the core is held in reset.
   assign start    = rst && (state_q == IDLE) && mac_ok && !stall_d && !flush_d;
   assign accept   = (state_q == ISSUE) && valid_q && mac_ready;
   assign stall_fd = start || (state_q == ISSUE);

   assign bubble = flush_e || stall_fd || flush_d;

   always_comb begin
      ctl_d = bubble ? 11'd0 : {rw, mw, as, jp, br, wd, rs, alu};
   end

   function automatic logic seq_last(input logic [1:0] m,
                                     input logic [IDX_W-1:0] r,
                                     input logic [IDX_W-1:0] c);
      logic l;
      l = 1'b1;
      case (m)
         M_MATVEC: l = (r == LAST_IDX) && (c == LAST_IDX);
         M_VEC:    l = (c == LAST_IDX);
         M_CLR:    l = 1'b1;
         default:  l = 1'b1;
      endcase
      return l;
   endfunction

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      mode_d  = mode_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ISSUE;
               row_d   = '0;
               col_d   = '0;
               mode_d  = funct3_d[1:0];
            end
         end
         ISSUE: begin
            if (accept) begin
               if (last_q) begin
                  state_d = DONE;
                  row_d   = '0;
                  col_d   = '0;
               end else if (col_q == LAST_IDX) begin
                  col_d = '0;
                  row_d = row_q + IDX_W'(1);
               end else begin
                  col_d = col_q + IDX_W'(1);
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      valid_d = (state_d == ISSUE);
      busy_d  = (state_d != IDLE);
      last_d  = (state_d == ISSUE) && seq_last(mode_d, row_d, col_d);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctl_q   <= '0;
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
         mode_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         ctl_q   <= ctl_d;
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         mode_q  <= mode_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
      end
   end

   assign {reg_write_e, mem_write_e, alu_src_e, jump_e, branch_e, wd3_src_e,
           result_src_e, alu_control_e} = ctl_q;

   assign mac_valid = valid_q;
   assign mac_mode  = mode_q;
   assign mac_row   = row_q;
   assign mac_col   = col_q;
   assign mac_last  = last_q;
   assign mac_busy  = busy_q;

endmodule

// File: tb/tb_decode_ctrl_mac_seq.sv
// Scoreboard bench for decode_ctrl_mac_seq: stimulus queues expectations,
// a negedge monitor retires them and checks every presented MAC beat.
module tb_decode_ctrl_mac_seq;

   localparam int DIM = 4;
   localparam int IW  = 2;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JLR = 7'b1100111;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_C0  = 7'b0001011;
   localparam logic [6:0] OP_BAD = 7'b1111111;

   localparam int S_E = 0, S_IMM = 1, S_ILL = 2, S_STL = 3;
   localparam int S_VLD = 4, S_BSY = 5, S_ROW = 6, S_COL = 7;

   logic          clk = 1'b0;
   logic          rst;
   logic [6:0]    op_d;
   logic [2:0]    funct3_d;
   logic [6:0]    funct7_d;
   logic          stall_d, flush_d, flush_e, mac_ready;
   logic [2:0]    imm_src_d;
   logic          illegal_d;
   logic          reg_write_e, mem_write_e, alu_src_e, jump_e, branch_e, wd3_src_e;
   logic [1:0]    result_src_e;
   logic [2:0]    alu_control_e;
   logic          stall_fd, mac_valid, mac_last, mac_busy;
   logic [1:0]    mac_mode;
   logic [IW-1:0] mac_row, mac_col;

   decode_ctrl_mac_seq #(.DIM(DIM)) dut (
      .clk(clk), .rst(rst),
      .op_d(op_d), .funct3_d(funct3_d), .funct7_d(funct7_d),
      .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
      .mac_ready(mac_ready),
      .imm_src_d(imm_src_d), .illegal_d(illegal_d),
      .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
      .alu_src_e(alu_src_e), .jump_e(jump_e), .branch_e(branch_e),
      .wd3_src_e(wd3_src_e), .result_src_e(result_src_e),
      .alu_control_e(alu_control_e), .stall_fd(stall_fd),
      .mac_valid(mac_valid), .mac_mode(mac_mode),
      .mac_row(mac_row), .mac_col(mac_col),
      .mac_last(mac_last), .mac_busy(mac_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      int          sel;
      logic [15:0] exp;
      string       name;
   } exp_t;

   typedef struct {
      logic [1:0]    mode;
      logic [IW-1:0] row;
      logic [IW-1:0] col;
      logic          last;
   } beat_t;

   exp_t  eq[$];
   beat_t bq[$];
   int    cyc   = 0;
   int    n_cmp = 0;
   int    n_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [10:0] ectl(logic rw, logic mw, logic as, logic j,
                                        logic b, logic wd, logic [1:0] rs,
                                        logic [2:0] alu);
      return {rw, mw, as, j, b, wd, rs, alu};
   endfunction

   function automatic logic [15:0] getv(int sel);
      logic [15:0] v;
      v = '0;
      case (sel)
         S_E:   v = {5'd0, reg_write_e, mem_write_e, alu_src_e, jump_e,
                     branch_e, wd3_src_e, result_src_e, alu_control_e};
         S_IMM: v = {13'd0, imm_src_d};
         S_ILL: v = {15'd0, illegal_d};
         S_STL: v = {15'd0, stall_fd};
         S_VLD: v = {15'd0, mac_valid};
         S_BSY: v = {15'd0, mac_busy};
         S_ROW: v = {14'd0, mac_row};
         S_COL: v = {14'd0, mac_col};
         default: v = 16'hdead;
      endcase
      return v;
   endfunction

   task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   task automatic want(int due, int sel, logic [15:0] v, string nm);
      exp_t e;
      e.due  = due;
      e.sel  = sel;
      e.exp  = v;
      e.name = nm;
      eq.push_back(e);
   endtask

   always @(negedge clk) begin
      beat_t b;
      for (int i = 0; i < eq.size(); ) begin
         if (eq[i].due <= cyc) begin
            chk(eq[i].name, getv(eq[i].sel), eq[i].exp);
            eq.delete(i);
         end else begin
            i++;
         end
      end
      if (rst && mac_valid) begin
         if (bq.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL beat_unexpected at cycle %0d: got row %0d col %0d, none expected",
                     cyc, mac_row, mac_col);
         end else begin
            b = bq[0];
            chk("beat", {9'd0, mac_mode, mac_row, mac_col, mac_last},
                {9'd0, b.mode, b.row, b.col, b.last});
            if (mac_ready) bq.pop_front();
         end
      end
   end

   always @(negedge clk) begin
      if (rst && mac_busy)
         assert (!flush_d) else $error("flush_d asserted during MAC sequence");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                        logic sd, logic fd, logic fe);
      op_d     = op;
      funct3_d = f3;
      funct7_d = f7;
      stall_d  = sd;
      flush_d  = fd;
      flush_e  = fe;
   endtask

   task automatic dec(string nm, logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                      logic [10:0] e, logic [2:0] imm, logic ill,
                      logic fd, logic fe);
      drive(op, f3, f7, 1'b0, fd, fe);
      want(cyc, S_IMM, {13'd0, imm}, {nm, "_imm"});
      want(cyc, S_ILL, {15'd0, ill}, {nm, "_ill"});
      want(cyc, S_STL, 16'd0, {nm, "_stall"});
      want(cyc + 1, S_E, (fd || fe) ? 16'd0 : {5'd0, e}, {nm, "_e"});
      tick();
   endtask

   task automatic run_mac(logic [2:0] f3, int period);
      int beats, acc, i;
      beat_t b;
      beats = (f3 == 3'b000) ? DIM * DIM : (f3 == 3'b001) ? DIM : 1;
      for (int k = 0; k < beats; k++) begin
         b.mode = f3[1:0];
         b.row  = (f3 == 3'b000) ? IW'(k / DIM) : '0;
         b.col  = (f3 == 3'b010) ? '0 : IW'(k % DIM);
         b.last = (k == beats - 1);
         bq.push_back(b);
      end
      drive(OP_C0, f3, 7'd0, 1'b0, 1'b0, 1'b0);
      mac_ready = 1'b0;
      want(cyc, S_STL, 16'd1, "mac_start_stall");
      want(cyc, S_ILL, 16'd0, "mac_start_ill");
      want(cyc, S_BSY, 16'd0, "mac_start_busy");
      want(cyc + 1, S_E, 16'd0, "mac_start_e");
      tick();
      acc = 0;
      i   = 0;
      while (acc < beats) begin
         mac_ready = (i % period == 0);
         want(cyc, S_STL, 16'd1, "mac_issue_stall");
         want(cyc, S_VLD, 16'd1, "mac_issue_valid");
         want(cyc, S_BSY, 16'd1, "mac_issue_busy");
         want(cyc + 1, S_E, 16'd0, "mac_issue_e");
         if (mac_ready) acc++;
         i++;
         tick();
      end
      mac_ready = 1'b0;
      want(cyc, S_STL, 16'd0, "mac_done_stall");
      want(cyc, S_VLD, 16'd0, "mac_done_valid");
      want(cyc, S_BSY, 16'd1, "mac_done_busy");
      want(cyc + 1, S_E, 16'd0, "mac_done_e");
      want(cyc + 1, S_BSY, 16'd0, "mac_idle_busy");
      tick();
   endtask

   initial begin
      rst       = 1'b0;
      mac_ready = 1'b0;
      drive(7'd0, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0);
      #2;
      chk("rst_e", getv(S_E), 16'd0);
      chk("rst_valid", getv(S_VLD), 16'd0);
      chk("rst_busy", getv(S_BSY), 16'd0);
      chk("rst_stall", getv(S_STL), 16'd0);
      chk("rst_row", getv(S_ROW), 16'd0);
      chk("rst_col", getv(S_COL), 16'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      dec("add", OP_R, 3'd0, 7'd0, ectl(1,0,0,0,0,0,2'b00,3'b000), 3'd0, 0, 0, 0);
      dec("sub", OP_R, 3'd0, 7'b0100000, ectl(1,0,0,0,0,0,2'b00,3'b001), 3'd0, 0, 0, 0);
      dec("and", OP_R, 3'd7, 7'd0, ectl(1,0,0,0,0,0,2'b00,3'b010), 3'd0, 0, 0, 0);
      dec("or", OP_R, 3'd6, 7'd0, ectl(1,0,0,0,0,0,2'b00,3'b011), 3'd0, 0, 0, 0);
      dec("slt", OP_R, 3'd2, 7'd0, ectl(1,0,0,0,0,0,2'b00,3'b100), 3'd0, 0, 0, 0);
      dec("r_bad", OP_R, 3'd0, 7'd1, ectl(1,0,0,0,0,0,2'b00,3'b000), 3'd0, 1, 0, 0);
      dec("lw", OP_LW, 3'd2, 7'd0, ectl(1,0,1,0,0,0,2'b01,3'b000), 3'd0, 0, 0, 0);
      dec("sw", OP_SW, 3'd2, 7'd0, ectl(0,1,1,0,0,0,2'b00,3'b000), 3'd1, 0, 0, 0);
      dec("beq", OP_BR, 3'd0, 7'd0, ectl(0,0,0,0,1,0,2'b00,3'b001), 3'd2, 0, 0, 0);
      dec("blt", OP_BR, 3'd4, 7'd0, ectl(0,0,0,0,1,0,2'b00,3'b100), 3'd2, 0, 0, 0);
      dec("lui", OP_LUI, 3'd0, 7'd0, ectl(1,0,0,0,0,0,2'b11,3'b000), 3'd3, 0, 0, 0);
      dec("jal", OP_JAL, 3'd0, 7'd0, ectl(1,0,0,1,0,1,2'b10,3'b000), 3'd4, 0, 0, 0);
      dec("jalr", OP_JLR, 3'd0, 7'd0, ectl(1,0,1,1,0,1,2'b10,3'b000), 3'd0, 0, 0, 0);
      dec("xori", OP_I, 3'd4, 7'd0, ectl(1,0,1,0,0,0,2'b00,3'b101), 3'd0, 0, 0, 0);
      dec("ori", OP_I, 3'd6, 7'd0, ectl(1,0,1,0,0,0,2'b00,3'b011), 3'd0, 0, 0, 0);
      dec("slli", OP_I, 3'd1, 7'd0, ectl(1,0,1,0,0,0,2'b00,3'b000), 3'd0, 0, 0, 0);
      dec("bad_op", OP_BAD, 3'd0, 7'd0, 11'd0, 3'd0, 1, 0, 0);
      dec("mac_bad", OP_C0, 3'd3, 7'd0, 11'd0, 3'd0, 1, 0, 0);
      want(cyc, S_BSY, 16'd0, "mac_bad_busy");
      dec("add_fd", OP_R, 3'd0, 7'd0, 11'd0, 3'd0, 0, 1, 0);
      dec("add_fe", OP_R, 3'd0, 7'd0, 11'd0, 3'd0, 0, 0, 1);
      dec("mac_fd", OP_C0, 3'd0, 7'd0, 11'd0, 3'd0, 0, 1, 0);
      want(cyc, S_BSY, 16'd0, "mac_fd_busy");

      for (int k = 0; k < 3; k++) begin
         drive(OP_C0, 3'd0, 7'd0, 1'b1, 1'b0, 1'b0);
         want(cyc, S_STL, 16'd0, "mac_sd_stall");
         want(cyc, S_BSY, 16'd0, "mac_sd_busy");
         want(cyc + 1, S_E, 16'd0, "mac_sd_e");
         tick();
      end
      run_mac(3'b000, 1);
      dec("addi", OP_I, 3'd0, 7'd0, ectl(1,0,1,0,0,0,2'b00,3'b000), 3'd0, 0, 0, 0);

      run_mac(3'b001, 3);
      run_mac(3'b010, 1);
      dec("add2", OP_R, 3'd0, 7'd0, ectl(1,0,0,0,0,0,2'b00,3'b000), 3'd0, 0, 0, 0);

      for (int k = 0; k < 5; k++) begin
         beat_t b;
         b.mode = 2'd0;
         b.row  = IW'(k / DIM);
         b.col  = IW'(k % DIM);
         b.last = 1'b0;
         bq.push_back(b);
      end
      drive(OP_C0, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0);
      mac_ready = 1'b1;
      want(cyc, S_STL, 16'd1, "mid_start_stall");
      tick();
      for (int k = 0; k < 5; k++) begin
         want(cyc, S_VLD, 16'd1, "mid_issue_valid");
         tick();
      end
      #2;
      rst = 1'b0;
      chk("mid_beats_done", 16'(bq.size()), 16'd0);
      eq.delete();
      bq.delete();
      #1;
      chk("mid_rst_valid", getv(S_VLD), 16'd0);
      chk("mid_rst_busy", getv(S_BSY), 16'd0);
      chk("mid_rst_stall", getv(S_STL), 16'd0);
      chk("mid_rst_e", getv(S_E), 16'd0);
      chk("mid_rst_row", getv(S_ROW), 16'd0);
      mac_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      dec("add3", OP_R, 3'd0, 7'b0100000, ectl(1,0,0,0,0,0,2'b00,3'b001), 3'd0, 0, 0, 0);
      want(cyc, S_BSY, 16'd0, "post_rst_busy");
      dec("lw2", OP_LW, 3'd2, 7'd0, ectl(1,0,1,0,0,0,2'b01,3'b000), 3'd0, 0, 0, 0);

      repeat (3) tick();
      chk("beats_left", 16'(bq.size()), 16'd0);
      chk("exp_left", 16'(eq.size()), 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
